ijtag_scan_sequencer: RTL and testbench

IJTAG_SCAN_SEQUENCER -- requirements
Module: ijtag_scan_sequencer

---
 rtl/ijtag_scan_sequencer.sv | 86 ++++++++
 tb/tb_ijtag_scan_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ijtag_scan_sequencer.sv
// ijtag_scan_sequencer: round-robin arbitrated IJTAG DR scan sequencer for two requesters
module ijtag_scan_sequencer #(
  parameter int         SCAN_LEN = 16,
  parameter logic [3:0] IJTAG_IR = 4'b1000
) (
  input  logic                tck,
  input  logic                trst,
  input  logic [1:0]          req,
  input  logic [SCAN_LEN-1:0] wdata0,
  input  logic [SCAN_LEN-1:0] wdata1,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [SCAN_LEN-1:0] rdata,
  output logic                busy,
  output logic [3:0]          ir_o,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                tdi_o,
  input  logic                tdo_i
);
  localparam int CW = $clog2(SCAN_LEN);
  typedef enum logic [2:0] {IDLE, SELECT, CAPTURE, SHIFT, UPDATE, DONE} state_t;
  state_t              state_q, state_d;
  logic [SCAN_LEN-1:0] sr_q, sr_d, rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                owner_q, owner_d, last_q, last_d, win;
  // arbitration, next-state and datapath updates
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    win     = (req == 2'b11) ? ~last_q : req[1];
    case (state_q)
      IDLE: if (req != 2'b00) begin
        state_d = SELECT;
        owner_d = win;
        last_d  = win;
        sr_d    = win ? wdata1 : wdata0;
      end
      SELECT:  state_d = CAPTURE;
      CAPTURE: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        sr_d    = sr_q >> 1;
        rdata_d = {tdo_i, rdata_q[SCAN_LEN-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SCAN_LEN - 1)) ? UPDATE : SHIFT;
      end
      UPDATE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register; reset aborts any transaction and restores requester-0 priority
  always_ff @(posedge tck) begin
    if (trst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign gnt        = (state_q == SELECT) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign done       = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign ir_o       = (state_q inside {SELECT, CAPTURE, SHIFT, UPDATE}) ? IJTAG_IR : 4'b0000;
  assign capture_dr = state_q == CAPTURE;
  assign shift_dr   = state_q == SHIFT;
  assign update_dr  = state_q == UPDATE;
  assign tdi_o      = (state_q == SHIFT) & sr_q[0];
  assign rdata      = rdata_q;
endmodule

// File: tb/tb_ijtag_scan_sequencer.sv
// tb_ijtag_scan_sequencer: scoreboard bench for the IJTAG scan sequencer (16-bit and 4-bit instances)
module tb_ijtag_scan_sequencer;
  typedef struct {
    logic [1:0]  own;
    logic [15:0] rd;
    logic [15:0] wd;
    int          gap;
  } exp_t;
  logic        tck = 1'b0, trst = 1'b1;
  logic [1:0]  req = 2'b00, req4 = 2'b00;
  logic [15:0] w0 = '0, w1 = '0, pre16 = '0, m16, rdata16;
  logic [3:0]  w4 = '0, pre4 = '0, m4, rdata4, ir16, ir4;
  logic [1:0]  gnt16, done16, gnt4, done4;
  logic        busy16, cap16, sh16, upd16, tdi16, busy4, cap4, sh4, upd4, tdi4;
  logic        chk_zero = 1'b0, fin = 1'b0;
  exp_t        q[$], q4[$], e;
  int          checks = 0, failures = 0, cyc = 0;
  int          gcyc = 0, ldone = -1, gap = -1, nsh = 0, ncap = 0, nupd = 0, gcyc4 = 0, nsh4 = 0;
  logic [1:0]  g = '0, g4 = '0;
  logic [15:0] tw = '0;
  logic [3:0]  tw4 = '0;

  always #5 tck = ~tck;

  ijtag_scan_sequencer dut16 (
    .tck(tck), .trst(trst), .req(req), .wdata0(w0), .wdata1(w1), .gnt(gnt16), .done(done16),
    .rdata(rdata16), .busy(busy16), .ir_o(ir16), .capture_dr(cap16), .shift_dr(sh16),
    .update_dr(upd16), .tdi_o(tdi16), .tdo_i(m16[0])
  );

  ijtag_scan_sequencer #(.SCAN_LEN(4)) dut4 (
    .tck(tck), .trst(trst), .req(req4), .wdata0(w4), .wdata1(4'h0), .gnt(gnt4), .done(done4),
    .rdata(rdata4), .busy(busy4), .ir_o(ir4), .capture_dr(cap4), .shift_dr(sh4),
    .update_dr(upd4), .tdi_o(tdi4), .tdo_i(m4[0])
  );

  always @(posedge tck) begin
    cyc <= cyc + 1;
    if (cap16) m16 <= pre16;
    else if (sh16) m16 <= m16 >> 1;
    if (cap4) m4 <= pre4;
    else if (sh4) m4 <= m4 >> 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge tck) begin
    if (chk_zero) begin
      chk("zero_outputs16", {3'b0, gnt16, done16, busy16, ir16, cap16, sh16, upd16, tdi16, rdata16}, 32'h0);
      chk("zero_outputs4", {15'b0, gnt4, done4, busy4, ir4, cap4, sh4, upd4, tdi4, rdata4}, 32'h0);
    end
    if (trst) begin
      nsh = 0; ncap = 0; nupd = 0; nsh4 = 0;
    end else begin
      chk("dr_excl16", ($countones({cap16, sh16, upd16}) > 1) ? 1 : 0, 0);
      chk("tdi_idle16", (!sh16 && tdi16) ? 1 : 0, 0);
      chk("ir16", 32'(ir16), (busy16 && done16 == 2'b00) ? 32'h8 : 32'h0);
      if (gnt16 != 2'b00) begin
        g = gnt16; gap = (ldone < 0) ? -1 : cyc - ldone; gcyc = cyc;
        nsh = 0; ncap = 0; nupd = 0; tw = '0;
      end
      if (cap16) ncap++;
      if (sh16) begin
        nsh++;
        tw = {tdi16, tw[15:1]};
      end
      if (upd16) nupd++;
      if (done16 != 2'b00) begin
        if (q.size() == 0) chk("unexpected_done16", 32'(done16), 0);
        else begin
          e = q.pop_front();
          chk("done_owner16", 32'(done16), 32'(e.own));
          chk("gnt_owner16", 32'(g), 32'(e.own));
          chk("rdata16", 32'(rdata16), 32'(e.rd));
          chk("tdi_stream16", 32'(tw), 32'(e.wd));
          chk("latency16", cyc - gcyc + 1, 20);
          chk("shift_cycles16", nsh, 16);
          chk("capture_cycles16", ncap, 1);
          chk("update_cycles16", nupd, 1);
          if (e.gap >= 0) chk("idle_gap16", gap, e.gap);
        end
        ldone = cyc;
      end
      chk("dr_excl4", ($countones({cap4, sh4, upd4}) > 1) ? 1 : 0, 0);
      if (gnt4 != 2'b00) begin
        g4 = gnt4; gcyc4 = cyc; nsh4 = 0; tw4 = '0;
      end
      if (sh4) begin
        nsh4++;
        tw4 = {tdi4, tw4[3:1]};
      end
      if (done4 != 2'b00) begin
        if (q4.size() == 0) chk("unexpected_done4", 32'(done4), 0);
        else begin
          e = q4.pop_front();
          chk("done_owner4", 32'(done4), 32'(e.own));
          chk("gnt_owner4", 32'(g4), 32'(e.own));
          chk("rdata4", 32'(rdata4), 32'(e.rd));
          chk("tdi_stream4", 32'(tw4), 32'(e.wd));
          chk("latency4", cyc - gcyc4 + 1, 8);
          chk("shift_cycles4", nsh4, 4);
        end
      end
    end
    if (fin) begin
      chk("queue16_drained", q.size(), 0);
      chk("queue4_drained", q4.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic cyc_(input int n);
    repeat (n) @(posedge tck);
    #1;
  endtask

  task automatic serve(input logic [1:0] bits, input int n, input bit hold);
    int got = 0;
    req = bits;
    for (int i = 0; i < 400 && got < n; i++) begin
      cyc_(1);
      if (gnt16 != 2'b00) begin
        got++;
        if (!hold) req = req & ~gnt16;
      end
    end
    req = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy16 || busy4 || q.size() != 0 || q4.size() != 0); i++) cyc_(1);
    cyc_(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge tck);
    #1;
    chk_zero = 1'b1;
    cyc_(2);
    chk_zero = 1'b0;
    trst = 1'b0;
    cyc_(1);
    w0 = 16'hA5C3; pre16 = 16'h1234;
    q.push_back('{2'b01, 16'h1234, 16'hA5C3, -1});
    serve(2'b01, 1, 1'b0);
    wait_idle();
    trst = 1'b1;
    cyc_(1);
    trst = 1'b0;
    w0 = 16'h3C96; w1 = 16'h5A0F; pre16 = 16'hBEEF;
    q.push_back('{2'b01, 16'hBEEF, 16'h3C96, -1});
    q.push_back('{2'b10, 16'hBEEF, 16'h5A0F, 2});
    serve(2'b11, 2, 1'b0);
    wait_idle();
    pre16 = 16'hC0DE;
    q.push_back('{2'b01, 16'hC0DE, 16'h3C96, -1});
    q.push_back('{2'b10, 16'hC0DE, 16'h5A0F, 2});
    q.push_back('{2'b01, 16'hC0DE, 16'h3C96, 2});
    q.push_back('{2'b10, 16'hC0DE, 16'h5A0F, 2});
    serve(2'b11, 4, 1'b1);
    wait_idle();
    w0 = 16'hFFFF; pre16 = 16'h8001;
    serve(2'b01, 1, 1'b0);
    for (int i = 0; i < 10 && !sh16; i++) cyc_(1);
    cyc_(6);
    trst = 1'b1;
    cyc_(1);
    chk_zero = 1'b1;
    trst = 1'b0;
    cyc_(4);
    chk_zero = 1'b0;
    w1 = 16'h0F0F; pre16 = 16'h7E81;
    q.push_back('{2'b10, 16'h7E81, 16'h0F0F, -1});
    serve(2'b10, 1, 1'b0);
    wait_idle();
    w0 = 16'h2468; w1 = 16'hACE1; pre16 = 16'h9999;
    q.push_back('{2'b01, 16'h9999, 16'h2468, -1});
    q.push_back('{2'b10, 16'h9999, 16'hACE1, 2});
    serve(2'b01, 1, 1'b0);
    cyc_(3);
    req = 2'b10;
    cyc_(1);
    req = 2'b00;
    cyc_(2);
    serve(2'b10, 1, 1'b0);
    wait_idle();
    w4 = 4'hB; pre4 = 4'h6;
    q4.push_back('{2'b01, 16'h0006, 16'h000B, -1});
    req4 = 2'b01;
    for (int i = 0; i < 50 && gnt4 == 2'b00; i++) cyc_(1);
    req4 = 2'b00;
    wait_idle();
    fin = 1'b1;
    cyc_(5);
  end
endmodule
